bus_arbiter: RTL and testbench

Shares the single serial slave interface (swdata/smode/mvalid forward, srdata/svalid return) between NUM_MASTERS bus masters. Masters request with breq and receive a one-hot grant. Arbitration is round-robin. The granted master's serial lines are muxed onto the slave side, and slave return lines are gated back to the owner only. The block sits between the master ports and a slave instance in the system bus top level.

---
 rtl/bus_arbiter.sv | 161 ++++++++++++++++
 tb/tb_bus_arbiter.sv | 196 +++++++++++++++++++
 2 files changed

// File: rtl/bus_arbiter.sv
// bus_arbiter: round-robin owner of the shared serial slave port, with one-hot registered grant.
// Optional owner-idle grant revocation is compiled in with `define ARB_TIMEOUT_EN.
`default_nettype none

module bus_arbiter #(
  parameter int NUM_MASTERS = 2,
  parameter int TIMEOUT     = 64
) (
  input  logic                   clk,
  input  logic                   rstn,
  input  logic [NUM_MASTERS-1:0] breq,
  output logic [NUM_MASTERS-1:0] bgrant,
  input  logic [NUM_MASTERS-1:0] mwdata,
  input  logic [NUM_MASTERS-1:0] mmode,
  input  logic [NUM_MASTERS-1:0] mvalid_in,
  output logic                   swdata,
  output logic                   smode,
  output logic                   mvalid,
  input  logic                   srdata,
  input  logic                   svalid,
  output logic [NUM_MASTERS-1:0] mrdata,
  output logic [NUM_MASTERS-1:0] msvalid,
  output logic [((NUM_MASTERS > 1) ? $clog2(NUM_MASTERS) : 1)-1:0] owner,
  output logic                   busy,
  output logic                   timeout
);

  localparam int OW = (NUM_MASTERS > 1) ? $clog2(NUM_MASTERS) : 1;
  localparam int SW = OW + 1;

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_GRANTED = 2'd1,
    S_RELEASE = 2'd2
  } state_t;

  state_t                 r_state, w_state_nxt;
  logic [NUM_MASTERS-1:0] r_bgrant, w_bgrant_nxt, w_req;
  logic [OW-1:0]          r_owner, w_owner_nxt, r_ptr, w_ptr_nxt, w_win;
  logic                   r_busy, w_busy_nxt, w_found, w_tmo_hit;
  logic [SW-1:0]          w_sum;

`ifdef ARB_TIMEOUT_EN
  localparam int CW = $clog2(TIMEOUT + 1);
  logic [CW-1:0]          r_idle_cnt;
  logic [NUM_MASTERS-1:0] r_mask;
  logic                   r_timeout;

  assign w_req     = breq & ~r_mask;
  assign w_tmo_hit = (r_state == S_GRANTED) && breq[r_owner] && !mvalid_in[r_owner] &&
                     (r_idle_cnt == CW'(TIMEOUT - 1));
  assign timeout   = r_timeout;

  // Mask bit is set on revocation and only drops once the master lets go of breq.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_idle_cnt <= '0;
      r_mask     <= '0;
      r_timeout  <= 1'b0;
    end else begin
      r_timeout <= w_tmo_hit;
      r_mask    <= (r_mask & breq) | (w_tmo_hit ? (NUM_MASTERS'(1) << r_owner) : '0);
      if (r_state != S_GRANTED || mvalid_in[r_owner])
        r_idle_cnt <= '0;
      else
        r_idle_cnt <= r_idle_cnt + 1'b1;
    end
  end
`else
  assign w_req     = breq;
  assign w_tmo_hit = 1'b0;
  assign timeout   = (TIMEOUT < 0);
`endif

  // First unmasked requester at or after the rr pointer, wrapping.
  always_comb begin
    w_found = 1'b0;
    w_win   = '0;
    w_sum   = '0;
    for (int i = 0; i < NUM_MASTERS; i++) begin
      w_sum = {1'b0, r_ptr} + SW'(i);
      if (w_sum >= SW'(NUM_MASTERS))
        w_sum = w_sum - SW'(NUM_MASTERS);
      if (!w_found && w_req[w_sum[OW-1:0]]) begin
        w_found = 1'b1;
        w_win   = w_sum[OW-1:0];
      end
    end
  end

  always_comb begin
    w_state_nxt  = r_state;
    w_bgrant_nxt = r_bgrant;
    w_owner_nxt  = r_owner;
    w_busy_nxt   = r_busy;
    w_ptr_nxt    = r_ptr;
    case (r_state)
      S_IDLE: begin
        if (w_found) begin
          w_state_nxt  = S_GRANTED;
          w_bgrant_nxt = NUM_MASTERS'(1) << w_win;
          w_owner_nxt  = w_win;
          w_busy_nxt   = 1'b1;
          w_ptr_nxt    = (w_win == OW'(NUM_MASTERS - 1)) ? '0 : w_win + 1'b1;
        end
      end
      S_GRANTED: begin
        if (!breq[r_owner] || w_tmo_hit) begin
          w_state_nxt  = S_RELEASE;
          w_bgrant_nxt = '0;
          w_busy_nxt   = 1'b0;
        end
      end
      S_RELEASE: w_state_nxt = S_IDLE;
      default: begin
        w_state_nxt  = S_IDLE;
        w_bgrant_nxt = '0;
        w_busy_nxt   = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_state  <= S_IDLE;
      r_bgrant <= '0;
      r_owner  <= '0;
      r_busy   <= 1'b0;
      r_ptr    <= '0;
    end else begin
      r_state  <= w_state_nxt;
      r_bgrant <= w_bgrant_nxt;
      r_owner  <= w_owner_nxt;
      r_busy   <= w_busy_nxt;
      r_ptr    <= w_ptr_nxt;
    end
  end

  // Return lines reach only the owner; everything is quiet without a grant.
  always_comb begin
    swdata  = 1'b0;
    smode   = 1'b0;
    mvalid  = 1'b0;
    mrdata  = '0;
    msvalid = '0;
    if (r_busy) begin
      swdata           = mwdata[r_owner];
      smode            = mmode[r_owner];
      mvalid           = mvalid_in[r_owner];
      mrdata[r_owner]  = srdata;
      msvalid[r_owner] = svalid;
    end
  end

  assign bgrant = r_bgrant;
  assign owner  = r_owner;
  assign busy   = r_busy;

endmodule

`default_nettype wire

// File: tb/tb_bus_arbiter.sv
// Directed self-checking bench for bus_arbiter (two masters, TIMEOUT=8).
`default_nettype none

module tb_bus_arbiter;

  logic       clk = 1'b0;
  logic       rstn;
  logic [1:0] breq, bgrant, mwdata, mmode, mvalid_in, mrdata, msvalid;
  logic       swdata, smode, mvalid, srdata, svalid, busy, timeout;
  logic [0:0] owner;

  int n_checks = 0;
  int n_fail   = 0;

  bus_arbiter #(.NUM_MASTERS(2), .TIMEOUT(8)) dut (
    .clk(clk), .rstn(rstn), .breq(breq), .bgrant(bgrant), .mwdata(mwdata),
    .mmode(mmode), .mvalid_in(mvalid_in), .swdata(swdata), .smode(smode),
    .mvalid(mvalid), .srdata(srdata), .svalid(svalid), .mrdata(mrdata),
    .msvalid(msvalid), .owner(owner), .busy(busy), .timeout(timeout)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rstn = 1'b0; breq = 2'b00; mwdata = 2'b00; mmode = 2'b00; mvalid_in = 2'b00;
    srdata = 1'b0; svalid = 1'b0;
    tick();
    n_checks++; if (bgrant !== 2'b00) begin n_fail++; $display("FAIL reset_bgrant got %b exp 00", bgrant); end
    n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy got %b exp 0", busy); end
    n_checks++; if (timeout !== 1'b0) begin n_fail++; $display("FAIL reset_timeout got %b exp 0", timeout); end
    rstn = 1'b1;
    breq = 2'b01; mwdata = 2'b01; mvalid_in = 2'b01;
    tick();
    n_checks++; if (bgrant !== 2'b01 || swdata !== 1'b1 || mvalid !== 1'b1) begin
      n_fail++; $display("FAIL pre_reset_grant got g=%b sw=%b mv=%b exp 01/1/1", bgrant, swdata, mvalid); end
    #2 rstn = 1'b0;
    #1;
    n_checks++; if (bgrant !== 2'b00 || busy !== 1'b0) begin
      n_fail++; $display("FAIL midreset_grant got g=%b busy=%b exp 00/0", bgrant, busy); end
    n_checks++; if (swdata !== 1'b0 || mvalid !== 1'b0) begin
      n_fail++; $display("FAIL midreset_slave got sw=%b mv=%b exp 0/0", swdata, mvalid); end
    breq = 2'b10; mwdata = 2'b00; mvalid_in = 2'b00;
    #1 rstn = 1'b1;
    tick();
    n_checks++; if (bgrant !== 2'b10 || owner !== 1'b1 || busy !== 1'b1) begin
      n_fail++; $display("FAIL post_reset_grant got g=%b own=%b busy=%b exp 10/1/1", bgrant, owner, busy); end
    breq = 2'b00;
    tick();
    tick();
  endtask

  task automatic test_round_robin();
    logic [1:0] exp_g [4];
    exp_g = '{2'b01, 2'b10, 2'b01, 2'b10};
    breq = 2'b11;
    for (int k = 0; k < 4; k++) begin
      tick();
      n_checks++; if (bgrant !== exp_g[k] || owner !== exp_g[k][1]) begin
        n_fail++; $display("FAIL rr_grant%0d got g=%b own=%b exp %b", k, bgrant, owner, exp_g[k]); end
      tick(); tick(); tick();
      n_checks++; if (bgrant !== exp_g[k]) begin
        n_fail++; $display("FAIL rr_hold%0d got %b exp %b", k, bgrant, exp_g[k]); end
      breq = 2'b11 & ~exp_g[k];
      tick();
      n_checks++; if (bgrant !== 2'b00 || busy !== 1'b0 || timeout !== 1'b0) begin
        n_fail++; $display("FAIL rr_release%0d got g=%b busy=%b to=%b exp 00/0/0", k, bgrant, busy, timeout); end
      breq = (k < 3) ? 2'b11 : 2'b00;
      tick();
      n_checks++; if (bgrant !== 2'b00) begin
        n_fail++; $display("FAIL rr_idle%0d got %b exp 00", k, bgrant); end
    end
  endtask

  task automatic test_single();
    breq = 2'b01;
    tick();
    n_checks++; if (bgrant !== 2'b01 || busy !== 1'b1 || owner !== 1'b0) begin
      n_fail++; $display("FAIL single_grant got g=%b busy=%b own=%b exp 01/1/0", bgrant, busy, owner); end
    tick(); tick(); tick(); tick();
    n_checks++; if (bgrant !== 2'b01) begin n_fail++; $display("FAIL single_hold got %b exp 01", bgrant); end
    breq = 2'b00;
    tick();
    n_checks++; if (bgrant !== 2'b00 || busy !== 1'b0) begin
      n_fail++; $display("FAIL single_drop got g=%b busy=%b exp 00/0", bgrant, busy); end
    breq = 2'b01;
    tick();
    n_checks++; if (bgrant !== 2'b00) begin n_fail++; $display("FAIL single_turnaround got %b exp 00", bgrant); end
    tick();
    n_checks++; if (bgrant !== 2'b01) begin n_fail++; $display("FAIL single_regrant got %b exp 01", bgrant); end
    breq = 2'b00;
    tick(); tick();
  endtask

  task automatic test_mux();
    breq = 2'b10;
    tick();
    n_checks++; if (bgrant !== 2'b10 || owner !== 1'b1) begin
      n_fail++; $display("FAIL mux_grant got g=%b own=%b exp 10/1", bgrant, owner); end
    mwdata = 2'b01; mmode = 2'b01; mvalid_in = 2'b01;
    #1;
    n_checks++; if ({swdata, smode, mvalid} !== 3'b000) begin
      n_fail++; $display("FAIL mux_ignore_m0 got %b exp 000", {swdata, smode, mvalid}); end
    mwdata = 2'b10; mmode = 2'b10; mvalid_in = 2'b11;
    #1;
    n_checks++; if ({swdata, smode, mvalid} !== 3'b111) begin
      n_fail++; $display("FAIL mux_follow_m1 got %b exp 111", {swdata, smode, mvalid}); end
    mwdata = 2'b01;
    #1;
    n_checks++; if (swdata !== 1'b0) begin n_fail++; $display("FAIL mux_wdata_low got %b exp 0", swdata); end
    srdata = 1'b1; svalid = 1'b1;
    #1;
    n_checks++; if (msvalid !== 2'b10 || mrdata !== 2'b10) begin
      n_fail++; $display("FAIL mux_return got sv=%b rd=%b exp 10/10", msvalid, mrdata); end
    breq = 2'b11;
    tick();
    n_checks++; if (bgrant !== 2'b10) begin n_fail++; $display("FAIL mux_no_preempt got %b exp 10", bgrant); end
    breq = 2'b00; mwdata = 2'b11; mvalid_in = 2'b11;
    tick();
    n_checks++; if (msvalid !== 2'b00 || mrdata !== 2'b00 || swdata !== 1'b0 || mvalid !== 1'b0) begin
      n_fail++; $display("FAIL mux_idle_gate got sv=%b rd=%b sw=%b mv=%b exp 00/00/0/0", msvalid, mrdata, swdata, mvalid); end
    mwdata = 2'b00; mmode = 2'b00; mvalid_in = 2'b00; srdata = 1'b0; svalid = 1'b0;
    tick();
  endtask

`ifdef ARB_TIMEOUT_EN
  task automatic test_timeout();
    breq = 2'b11; mvalid_in = 2'b00;
    tick();
    n_checks++; if (bgrant !== 2'b01) begin n_fail++; $display("FAIL to_grant got %b exp 01", bgrant); end
    for (int i = 0; i < 7; i++) tick();
    n_checks++; if (bgrant !== 2'b01 || timeout !== 1'b0) begin
      n_fail++; $display("FAIL to_before got g=%b to=%b exp 01/0", bgrant, timeout); end
    tick();
    n_checks++; if (bgrant !== 2'b00 || timeout !== 1'b1) begin
      n_fail++; $display("FAIL to_revoke got g=%b to=%b exp 00/1", bgrant, timeout); end
    tick();
    n_checks++; if (timeout !== 1'b0 || bgrant !== 2'b00) begin
      n_fail++; $display("FAIL to_pulse_end got g=%b to=%b exp 00/0", bgrant, timeout); end
    tick();
    n_checks++; if (bgrant !== 2'b10) begin n_fail++; $display("FAIL to_next_owner got %b exp 10", bgrant); end
    breq = 2'b01;
    tick(); tick(); tick();
    n_checks++; if (bgrant !== 2'b00) begin n_fail++; $display("FAIL to_masked got %b exp 00", bgrant); end
    breq = 2'b00;
    tick();
    breq = 2'b01;
    tick();
    n_checks++; if (bgrant !== 2'b01) begin n_fail++; $display("FAIL to_unmasked got %b exp 01", bgrant); end
    breq = 2'b00;
    tick(); tick();
  endtask

  task automatic test_activity();
    int bad;
    bad = 0;
    breq = 2'b01; mvalid_in = 2'b00;
    tick();
    for (int c = 0; c < 50; c++) begin
      mvalid_in = (c % 7 == 6) ? 2'b01 : 2'b00;
      tick();
      if (bgrant !== 2'b01 || timeout !== 1'b0) bad++;
    end
    n_checks++; if (bad !== 0) begin
      n_fail++; $display("FAIL activity_hold got %0d bad cycles exp 0", bad); end
    breq = 2'b00; mvalid_in = 2'b00;
    tick(); tick();
  endtask
`endif

  initial begin
    test_reset();
    test_round_robin();
    test_single();
    test_mux();
`ifdef ARB_TIMEOUT_EN
    test_timeout();
    test_activity();
`endif
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog got timeout exp completion");
    $fatal(1);
  end

endmodule

`default_nettype wire
